alu_muldiv_control: RTL and testbench
=====================================

Name: alu_muldiv_control

Overview:
Next-generation ALU control for the single-issue integer datapath. It keeps the aluOp/funct decode to a 4-bit ALU operation and adds an iterative multiply/divide engine with architectural HI/LO registers and the MFHI/MFLO read path. It sits beside the main ALU in the execute stage. It raises a stall toward the hazard unit while a multi-cycle operation is pending.

Parameters:
WIDTH, 32, operand width and HI/LO width (min 4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
aluOp  input  2  main-control ALU class: 00 add, 01 sub, 10 R-type
funct  input  6  R-type function field
valid  input  1  execute-stage instruction valid (not bubbled or flushed)
opA  input  WIDTH  rs operand
opB  input  WIDTH  rt operand
operation  output  4  ALU op code, types package ALU_* constants
isMulDiv  output  1  current instruction is MULT/MULTU/DIV/DIVU
isMfHiLo  output  1  current instruction is MFHI/MFLO
hiloData  output  WIDTH  HI (MFHI) or LO (MFLO); 0 otherwise
stall  output  1  hold execute stage this cycle
busy  output  1  engine running
done  output  1  one-cycle pulse: HI/LO just updated

Behaviour:
- Decode (combinational): aluOp 00 -> ALU_ADD; 01 -> ALU_SUB; 10 with funct FUNC_ADD/SUB/AND/OR/SLT -> ALU_ADD/SUB/AND/OR/SLT; funct 100111 -> ALU_NOR. Any other combination, including aluOp 11 -> ALU_ADD.
- Muldiv funct codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. MFHI is 010000 and MFLO is 010010. All require aluOp=10.
- FSM states:
  - IDLE
  - RUN
  - FIXUP
- IDLE -> RUN on accept: valid & isMulDiv & state==IDLE. On accept, latch kind and signedness, latch |opA| and |opB| (signed ops), record result signs, clear counter. Exception: divisor==0 goes IDLE -> FIXUP directly.
- RUN: one bit per cycle, exactly WIDTH cycles.
  - Multiply: shift-add. The 2*WIDTH product accumulates in HI:LO scratch.
  - Divide: restoring division, yielding quotient and remainder.
  - RUN -> FIXUP when counter reaches WIDTH.
- FIXUP: apply signs and write HI/LO, then -> IDLE.
  - Multiply: HI:LO = product, negated if operand signs differ (signed only).
  - Divide: LO = quotient, HI = remainder. Quotient is negated if signs differ; remainder takes the dividend's sign.
- Latency: accept in cycle 0; RUN cycles 1..WIDTH; FIXUP cycle WIDTH+1; HI/LO visible and done=1 in cycle WIDTH+2. Divide-by-zero: FIXUP in cycle 1, done in cycle 2.
- Divide by zero: HI = dividend (unmodified opA), LO = all ones. No exception.
- Signed overflow (MIN / -1): LO = MIN, HI = 0. This is the natural result of the abs/negate path and must not be special-cased differently.
- busy = (state != IDLE).
- stall = (valid & isMulDiv & state==IDLE) | (valid & (isMulDiv | isMfHiLo) & busy). The accept cycle stalls. A back-to-back muldiv or MFHI/MFLO waits until busy falls. Non-muldiv instructions behind a running op are not stalled.
- hiloData is combinational from the HI/LO registers. It reflects only completed results, never scratch state.
- done is registered, high exactly one cycle. busy falls in the same cycle done rises.
- A muldiv presented while busy is not accepted. valid dropping mid-operation does not cancel it.
- reset (synchronous, any state): state=IDLE, HI=LO=0, counter=0, busy=0, done=0, stall follows inputs combinationally.

Test Plan:
- Decode sweep: aluOp=00, funct=x -> ALU_ADD; aluOp=01 -> ALU_SUB; aluOp=10 with each FUNC_* -> matching ALU_*; aluOp=10, funct=111111 -> ALU_ADD; aluOp=10, funct=100111 -> ALU_NOR.
- MULT, signed: opA=-3, opB=7, WIDTH=32 -> stall in cycle 0, busy cycles 1..33, done in cycle 34. LO=0xFFFFFFEB, HI=0xFFFFFFFF. MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
- DIV, signed: -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> done in cycle 2, LO=0xFFFFFFFF, HI=7. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Hazards: MFLO issued in cycle 5 of a running MULT -> stall held until done, then hiloData = new LO. An ADD issued while busy -> stall=0. A second MULT while busy -> not accepted until IDLE.
- Reset mid-operation: assert reset in cycle 10 of a DIV -> next cycle busy=0, HI=LO=0, no done pulse. A fresh MULT 5*6 afterwards -> LO=30, HI=0.
- Parameter sweep at WIDTH=8: MULT -128*-128 -> HI:LO=0x4000, done in cycle 10. Random signed/unsigned mul/div checked against a reference model.

Source files
------------

// File: rtl/alu_muldiv_control.sv
// ALU operation decode plus an iterative multiply/divide engine
// with architectural HI/LO registers and the MFHI/MFLO read path.
package alu_muldiv_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] FUNC_ADD   = 6'b100000;
    localparam logic [5:0] FUNC_SUB   = 6'b100010;
    localparam logic [5:0] FUNC_AND   = 6'b100100;
    localparam logic [5:0] FUNC_OR    = 6'b100101;
    localparam logic [5:0] FUNC_NOR   = 6'b100111;
    localparam logic [5:0] FUNC_SLT   = 6'b101010;
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
endpackage

module alu_muldiv_control #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       aluOp,
    input  logic [5:0]       funct,
    input  logic             valid,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [3:0]       operation,
    output logic             isMulDiv,
    output logic             isMfHiLo,
    output logic [WIDTH-1:0] hiloData,
    output logic             stall,
    output logic             busy,
    output logic             done
);
    import alu_muldiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, b_q;
    logic [WIDTH-1:0]   acc_hi_d, acc_lo_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q, dz_q, neg_q, neg_a_q, done_q;

    logic               rtype, accept, sgn, ge;
    logic [WIDTH-1:0]   a_abs, b_abs, quo_s, rem_s;
    logic [WIDTH:0]     sum, rsh;
    logic [2*WIDTH-1:0] prod, prod_s;

    always_comb begin
        operation = ALU_ADD;
        unique case (aluOp)
            2'b00: operation = ALU_ADD;
            2'b01: operation = ALU_SUB;
            2'b10: begin
                case (funct)
                    FUNC_ADD: operation = ALU_ADD;
                    FUNC_SUB: operation = ALU_SUB;
                    FUNC_AND: operation = ALU_AND;
                    FUNC_OR:  operation = ALU_OR;
                    FUNC_SLT: operation = ALU_SLT;
                    FUNC_NOR: operation = ALU_NOR;
                    default:  operation = ALU_ADD;
                endcase
            end
            default: operation = ALU_ADD;
        endcase
    end

    assign rtype    = (aluOp == 2'b10);
    assign isMulDiv = rtype & (funct[5:2] == 4'b0110);
    assign isMfHiLo = rtype & ((funct == FUNC_MFHI) | (funct == FUNC_MFLO));
    assign hiloData = !isMfHiLo ? '0 : (funct[1] ? lo_q : hi_q);

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign accept = valid & isMulDiv & (state_q == IDLE);
    assign stall  = accept | (valid & (isMulDiv | isMfHiLo) & busy);

    assign sgn   = ~funct[0];
    assign a_abs = (sgn & opA[WIDTH-1]) ? -opA : opA;
    assign b_abs = (sgn & opB[WIDTH-1]) ? -opB : opB;

    // One iteration: shift-add for multiply, restoring step for divide
    always_comb begin
        sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
        rsh = {acc_hi_q, acc_lo_q[WIDTH-1]};
        ge  = (rsh >= {1'b0, b_q});
        if (is_div_q) begin
            acc_hi_d = ge ? (rsh[WIDTH-1:0] - b_q) : rsh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ge};
        end else begin
            {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
        end
    end

    assign prod   = {acc_hi_q, acc_lo_q};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -acc_lo_q : acc_lo_q;
    assign rem_s  = neg_a_q ? -acc_hi_q : acc_hi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            neg_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        is_div_q <= funct[1];
                        dz_q     <= funct[1] & (opB == '0);
                        neg_q    <= sgn & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        neg_a_q  <= sgn & opA[WIDTH-1];
                        cnt_q    <= '0;
                        b_q      <= b_abs;
                        acc_lo_q <= a_abs;
                        // Divide by zero keeps the raw dividend for HI
                        if (funct[1] & (opB == '0)) begin
                            acc_hi_q <= opA;
                            state_q  <= FIXUP;
                        end else begin
                            acc_hi_q <= '0;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (dz_q) begin
                        hi_q <= acc_hi_q;
                        lo_q <= '1;
                    end else if (is_div_q) begin
                        hi_q <= rem_s;
                        lo_q <= quo_s;
                    end else begin
                        {hi_q, lo_q} <= prod_s;
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_control.sv
// Self-checking bench: decode table, directed muldiv vectors,
// hazard/reset sequences and randomized ops against a model.
module tb_alu_muldiv_control;
    import alu_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  aluOp = 2'b00;
    logic [5:0]  funct = 6'b0;
    logic        valid = 1'b0;
    logic [31:0] opA = 32'd0, opB = 32'd0;
    logic        sel = 1'b0;

    logic [3:0]  op32, op8;
    logic        md32, md8, mf32, mf8;
    logic [31:0] hl32;
    logic [7:0]  hl8;
    logic        st32, st8, bz32, bz8, dn32, dn8;

    logic        stall_s, busy_s, done_s;
    logic [31:0] hilo_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv_control #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .aluOp(aluOp), .funct(funct),
        .valid(valid & ~sel), .opA(opA), .opB(opB),
        .operation(op32), .isMulDiv(md32), .isMfHiLo(mf32),
        .hiloData(hl32), .stall(st32), .busy(bz32), .done(dn32)
    );

    alu_muldiv_control #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .aluOp(aluOp), .funct(funct),
        .valid(valid & sel), .opA(opA[7:0]), .opB(opB[7:0]),
        .operation(op8), .isMulDiv(md8), .isMfHiLo(mf8),
        .hiloData(hl8), .stall(st8), .busy(bz8), .done(dn8)
    );

    assign stall_s = sel ? st8 : st32;
    assign busy_s  = sel ? bz8 : bz32;
    assign done_s  = sel ? dn8 : dn32;
    assign hilo_s  = sel ? {24'd0, hl8} : hl32;

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic at width w
    task automatic model(input int w, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint unsigned mask, ua, ub, up;
        longint sa, sb, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= (64'd1 << (w - 1))) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb = (ub >= (64'd1 << (w - 1))) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        if (!f[1]) begin
            if (!f[0]) begin
                p  = sa * sb;
                up = longint'(p);
            end else begin
                up = ua * ub;
            end
            hi = 32'((up >> w) & mask);
            lo = 32'(up & mask);
        end else if (ub == 0) begin
            hi = 32'(ua);
            lo = 32'(mask);
        end else begin
            if (!f[0]) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
            end
            hi = 32'(longint'(r) & longint'(mask));
            lo = 32'(longint'(q) & longint'(mask));
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] eh,
                             input logic [31:0] el);
        aluOp = 2'b10;
        funct = FUNC_MFLO;
        valid = 1'b1;
        #1;
        chk({tag, "_lo"}, hilo_s, el);
        chk({tag, "_mf_stall"}, stall_s, 0);
        funct = FUNC_MFHI;
        #1;
        chk({tag, "_hi"}, hilo_s, eh);
    endtask

    task automatic run_op(input string tag, input int w, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int cyc, lat, bcnt;
        logic [31:0] bm;
        bm  = (w == 8) ? (b & 32'hFF) : b;
        lat = (f[1] && bm == 0) ? 2 : w + 2;
        sel = (w == 8);
        @(negedge clk);
        aluOp = 2'b10;
        funct = f;
        opA = a;
        opB = b;
        valid = 1'b1;
        #1;
        chk({tag, "_accept_stall"}, stall_s, 1);
        @(negedge clk);
        valid = 1'b0;
        aluOp = 2'b00;
        funct = 6'd0;
        #1;
        cyc = 1;
        bcnt = 0;
        while (!done_s && cyc < 200) begin
            if (busy_s) bcnt++;
            @(negedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_busy_cycles"}, bcnt, lat - 1);
        chk({tag, "_busy_at_done"}, busy_s, 0);
        read_hilo(tag, eh, el);
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk({tag, "_done_pulse"}, done_s, 0);
    endtask

    typedef struct {
        logic [1:0] aop;
        logic [5:0] fn;
        logic [3:0] eop;
        logic       emd;
        logic       emf;
    } dec_t;

    typedef struct {
        int          w;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } op_t;

    dec_t dec[15];
    op_t  ops[10];

    initial begin
        int cyc, bad, dcnt;
        logic [31:0] eh, el, a, b;
        logic [5:0] f;
        int w;

        dec[0]  = '{2'b00, 6'b000000, ALU_ADD, 1'b0, 1'b0};
        dec[1]  = '{2'b00, 6'b011000, ALU_ADD, 1'b0, 1'b0};
        dec[2]  = '{2'b01, 6'b100000, ALU_SUB, 1'b0, 1'b0};
        dec[3]  = '{2'b10, FUNC_ADD,  ALU_ADD, 1'b0, 1'b0};
        dec[4]  = '{2'b10, FUNC_SUB,  ALU_SUB, 1'b0, 1'b0};
        dec[5]  = '{2'b10, FUNC_AND,  ALU_AND, 1'b0, 1'b0};
        dec[6]  = '{2'b10, FUNC_OR,   ALU_OR,  1'b0, 1'b0};
        dec[7]  = '{2'b10, FUNC_SLT,  ALU_SLT, 1'b0, 1'b0};
        dec[8]  = '{2'b10, FUNC_NOR,  ALU_NOR, 1'b0, 1'b0};
        dec[9]  = '{2'b10, 6'b111111, ALU_ADD, 1'b0, 1'b0};
        dec[10] = '{2'b11, FUNC_SUB,  ALU_ADD, 1'b0, 1'b0};
        dec[11] = '{2'b10, FUNC_MULT, ALU_ADD, 1'b1, 1'b0};
        dec[12] = '{2'b10, FUNC_DIVU, ALU_ADD, 1'b1, 1'b0};
        dec[13] = '{2'b10, FUNC_MFHI, ALU_ADD, 1'b0, 1'b1};
        dec[14] = '{2'b11, FUNC_MFLO, ALU_ADD, 1'b0, 1'b0};

        ops[0] = '{32, FUNC_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB};
        ops[1] = '{32, FUNC_MULTU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE};
        ops[2] = '{32, FUNC_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        ops[3] = '{32, FUNC_DIVU,  32'd7, 32'd0, 32'd7, 32'hFFFFFFFF};
        ops[4] = '{32, FUNC_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
        ops[5] = '{32, FUNC_DIV,   32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};
        ops[6] = '{32, FUNC_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
        ops[7] = '{8,  FUNC_MULT,  32'h80, 32'h80, 32'h40, 32'h00};
        ops[8] = '{8,  FUNC_DIV,   32'h80, 32'hFF, 32'h00, 32'h80};
        ops[9] = '{8,  FUNC_DIVU,  32'd200, 32'd7, 32'd4, 32'd28};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy32", bz32, 0);
        chk("rst_done32", dn32, 0);
        chk("rst_busy8", bz8, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        read_hilo("rst", 32'd0, 32'd0);
        valid = 1'b0;

        for (int i = 0; i < 15; i++) begin
            aluOp = dec[i].aop;
            funct = dec[i].fn;
            #1;
            chk($sformatf("dec%0d_op", i), op32, dec[i].eop);
            chk($sformatf("dec%0d_md", i), md32, dec[i].emd);
            chk($sformatf("dec%0d_mf", i), mf32, dec[i].emf);
            chk($sformatf("dec%0d_op8", i), op8, dec[i].eop);
        end

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("dir%0d", i), ops[i].w, ops[i].fn,
                   ops[i].a, ops[i].b, ops[i].eh, ops[i].el);
        end

        // Hazards behind a running MULT 3*4
        sel = 1'b0;
        @(negedge clk);
        aluOp = 2'b10;
        funct = FUNC_MULT;
        opA = 32'd3;
        opB = 32'd4;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        funct = FUNC_ADD;
        valid = 1'b1;
        #1;
        chk("hz_add_stall", stall_s, 0);
        chk("hz_add_op", op32, ALU_ADD);
        chk("hz_add_busy", busy_s, 1);
        @(negedge clk);
        funct = FUNC_MULT;
        opA = 32'd7;
        opB = 32'd7;
        #1;
        chk("hz_mult2_stall", stall_s, 1);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        funct = FUNC_MFLO;
        valid = 1'b1;
        #1;
        cyc = 5;
        bad = 0;
        while (!done_s && cyc < 100) begin
            if (!stall_s) bad++;
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("hz_mflo_held", bad, 0);
        chk("hz_mflo_latency", cyc, 34);
        chk("hz_mflo_release", stall_s, 0);
        chk("hz_mflo_data", hilo_s, 12);
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk("hz_no_second_accept", busy_s, 0);

        // Reset in cycle 10 of a DIV
        @(negedge clk);
        aluOp = 2'b10;
        funct = FUNC_DIV;
        opA = 32'd100;
        opB = 32'd3;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid_busy", busy_s, 0);
        chk("rstmid_done", done_s, 0);
        read_hilo("rstmid", 32'd0, 32'd0);
        valid = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done_s) dcnt++;
        end
        chk("rstmid_no_done", dcnt, 0);
        run_op("post_rst", 32, FUNC_MULT, 32'd5, 32'd6, 32'd0, 32'd30);

        for (int i = 0; i < 60; i++) begin
            w = (i % 2 == 0) ? 32 : 8;
            f = {4'b0110, 2'($urandom_range(0, 3))};
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) a = (w == 32) ? 32'h80000000 : 32'h80;
            if (w == 8) begin
                a = a & 32'hFF;
                b = b & 32'hFF;
            end
            model(w, f, a, b, eh, el);
            run_op($sformatf("rnd%0d", i), w, f, a, b, eh, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
